alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-to-execute issue stage for the RISC-V core. Accepts one fetched instruction plus register-file read data, decodes it into the 6-bit ALU control code, selects and registers `operand_A`/`operand_B`/`branch_op`, and presents them to the ALU through a one-entry valid/ready pipeline register with stall and flush. It is the producer side of the ALU control/operand interface.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction/operands on `in_*` are valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of `in_instr`.
- `in_rs1_data`, `in_rs2_data`  in  32 each  register-file read data.
- `flush`  in  1  squash the held and incoming instruction.
- `out_valid`  out  1  registered bundle valid.
- `out_ready`  in  1  ALU/execute consumes the bundle.
- `ALU_Control`  out  6  ALU operation code.
- `operand_A`, `operand_B`  out  32 each  ALU operands.
- `branch_op`  out  1  conditional branch.
- `out_rd`  out  5  destination register; 0 for branches/stores.
- `out_pc`, `out_imm`  out  32 each  PC and sign-extended immediate for target computation.
- `illegal`  out  1  unsupported opcode/encoding.

## Operation
- ALU_Control codes: ADD 000000, SLL 000001, SLT 000010, SLTU 000011, XOR 000100, SRL 000101, OR 000110, AND 000111, SUB 001000, SRA 001101, BEQ/BNE/BLT/BGE/BLTU/BGEU 010000/010001/010100/010101/010110/010111, JAL 011111, JALR 111111.
- OP (0110011): ctrl {2'b00, funct7[5], funct3}; A=rs1, B=rs2. funct7 other than 0000000/0100000, or funct7[5]=1 with funct3 not 000/101 -> illegal.
- OP-IMM (0010011): ctrl {2'b00, (funct3==101)?funct7[5]:0, funct3}; A=rs1, B=imm_I (shamt = imm[4:0]).
- LOAD (0000011) / STORE (0100011): ADD; A=rs1, B=imm_I/imm_S; STORE rd=0.
- BRANCH (1100011): ctrl {3'b010, funct3}, branch_op=1, A=rs1, B=rs2, rd=0; funct3 010/011 -> illegal.
- JAL (1101111): 011111, A=pc+4, B=0, imm=imm_J. JALR (1100111): 111111, A=pc+4, B=0, imm=imm_I.
- LUI (0110111): ADD, A=0, B=imm_U. AUIPC (0010111): ADD, A=pc, B=imm_U.
- Any other opcode: illegal=1, ctrl ADD, A=B=0, rd=0, branch_op=0; bundle still issues.
- pc+4 wraps modulo 2^32.

## Timing
- Reset (async assert, sync release): out_valid=0, ALU_Control=000000, operands/out_pc/out_imm=0, out_rd=0, branch_op=0, illegal=0.
- in_ready = !out_valid || out_ready (combinational).
- Load on rising edge when in_valid && in_ready && !flush; bundle visible next cycle (latency 1).
- out_valid && !out_ready: all outputs held stable, in_ready=0 (stall).
- out_valid && out_ready && !in_valid: out_valid clears next edge.
- Consume and accept in the same cycle: new bundle replaces old, back-to-back throughput 1/cycle.
- flush: out_valid=0 next edge regardless of in_valid/out_ready; data fields may hold stale values.
- Reset asserted mid-stall: bundle dropped immediately.

## Structure
- Package `riscv_pkg`: opcode constants, ALU_Control code constants, XLEN.
- Sub-module `imm_gen`: combinational I/S/B/U/J immediate extraction, selected by opcode.
- Top: decode logic plus the valid/ready pipeline register.

## Test plan
- ADDI x1, x2, -3 (0xFFD10093), rs1=10 -> next cycle out_valid=1, ctrl 000000, A=10, B=0xFFFFFFFD, rd=1.
- SRAI x5, x6, 3 (0x40335293) -> ctrl 001101, B=3; SUB x3,x1,x2 (0x402081B3) -> ctrl 001000, B=rs2.
- BLTU (funct3 110), rs1=4, rs2=0xFFFFFFFB -> ctrl 010110, branch_op=1, rd=0; JAL at pc=0xFFFFFFFC -> ctrl 011111, A=0.
- Hold out_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs unchanged; release -> next instruction loads following edge.
- flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle; opcode 0x7F -> illegal=1, A=B=0.
- Assert reset during stall -> all outputs zero immediately, out_valid=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I opcode/ALU-control constants, immediate selector and the
// issue bundle carried from decode to execute.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SLL  = 6'b000001;
    localparam logic [5:0] ALU_SLT  = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;
    localparam logic [5:0] ALU_XOR  = 6'b000100;
    localparam logic [5:0] ALU_SRL  = 6'b000101;
    localparam logic [5:0] ALU_OR   = 6'b000110;
    localparam logic [5:0] ALU_AND  = 6'b000111;
    localparam logic [5:0] ALU_SUB  = 6'b001000;
    localparam logic [5:0] ALU_SRA  = 6'b001101;
    localparam logic [5:0] ALU_BEQ  = 6'b010000;
    localparam logic [5:0] ALU_BNE  = 6'b010001;
    localparam logic [5:0] ALU_BLT  = 6'b010100;
    localparam logic [5:0] ALU_BGE  = 6'b010101;
    localparam logic [5:0] ALU_BLTU = 6'b010110;
    localparam logic [5:0] ALU_BGEU = 6'b010111;
    localparam logic [5:0] ALU_JAL  = 6'b011111;
    localparam logic [5:0] ALU_JALR = 6'b111111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    typedef struct packed {
        logic [5:0]      ctrl;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic            branch;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } issue_bundle_t;

    function automatic imm_sel_e imm_sel_for(input logic [6:0] opcode);
        imm_sel_e sel;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: sel = IMM_I;
            OPC_STORE:                      sel = IMM_S;
            OPC_BRANCH:                     sel = IMM_B;
            OPC_LUI, OPC_AUIPC:             sel = IMM_U;
            OPC_JAL:                        sel = IMM_J;
            default:                        sel = IMM_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for RV32I; the format is chosen from
// the opcode, and formats without an immediate (OP, unknown) yield zero.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    imm_sel_e sel;

    assign sel = imm_sel_for(instr_i[6:0]);

    always_comb begin
        imm_o = '0;
        case (sel)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decodes one RV32I instruction into ALU
// control and operands and holds it in a one-entry valid/ready register.
module alu_issue_stage #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      ALU_Control,
    output logic [XLEN-1:0] operand_A,
    output logic [XLEN-1:0] operand_B,
    output logic            branch_op,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic            illegal
);

    import riscv_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_field;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus4;
    logic [5:0]      op_ctrl;
    logic [5:0]      opimm_ctrl;
    logic [5:0]      br_ctrl;
    logic            shift_imm;

    issue_bundle_t   bundle_d;
    issue_bundle_t   bundle_q;
    logic            valid_q;

    assign opcode   = in_instr[6:0];
    assign rd_field = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign pc_plus4 = in_pc + XLEN'(4);

    imm_gen u_imm_gen (
        .instr_i (in_instr),
        .imm_o   (imm)
    );

    // funct7[5] only selects SRAI among immediates; for other OP-IMM ops it is immediate data.
    assign op_ctrl    = {2'b00, funct7[5], funct3};
    assign opimm_ctrl = {2'b00, (funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
    assign br_ctrl    = {3'b010, funct3};
    assign shift_imm  = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        bundle_d         = '0;
        bundle_d.ctrl    = ALU_ADD;
        bundle_d.pc      = in_pc;
        bundle_d.imm     = imm;
        case (opcode)
            OPC_OP: begin
                bundle_d.ctrl    = op_ctrl;
                bundle_d.op_a    = in_rs1_data;
                bundle_d.op_b    = in_rs2_data;
                bundle_d.rd      = rd_field;
                bundle_d.illegal = !(((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) &&
                                     (op_ctrl inside {ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                                      ALU_XOR, ALU_SRL, ALU_OR, ALU_AND,
                                                      ALU_SUB, ALU_SRA}));
            end
            OPC_OP_IMM: begin
                bundle_d.ctrl = opimm_ctrl;
                bundle_d.op_a = in_rs1_data;
                bundle_d.op_b = shift_imm ? {{(XLEN-5){1'b0}}, imm[4:0]} : imm;
                bundle_d.rd   = rd_field;
            end
            OPC_LOAD: begin
                bundle_d.op_a = in_rs1_data;
                bundle_d.op_b = imm;
                bundle_d.rd   = rd_field;
            end
            OPC_STORE: begin
                bundle_d.op_a = in_rs1_data;
                bundle_d.op_b = imm;
            end
            OPC_BRANCH: begin
                bundle_d.ctrl    = br_ctrl;
                bundle_d.branch  = 1'b1;
                bundle_d.op_a    = in_rs1_data;
                bundle_d.op_b    = in_rs2_data;
                bundle_d.illegal = !(br_ctrl inside {ALU_BEQ, ALU_BNE, ALU_BLT,
                                                     ALU_BGE, ALU_BLTU, ALU_BGEU});
            end
            OPC_JAL: begin
                bundle_d.ctrl = ALU_JAL;
                bundle_d.op_a = pc_plus4;
                bundle_d.rd   = rd_field;
            end
            OPC_JALR: begin
                bundle_d.ctrl = ALU_JALR;
                bundle_d.op_a = pc_plus4;
                bundle_d.rd   = rd_field;
            end
            OPC_LUI: begin
                bundle_d.op_b = imm;
                bundle_d.rd   = rd_field;
            end
            OPC_AUIPC: begin
                bundle_d.op_a = in_pc;
                bundle_d.op_b = imm;
                bundle_d.rd   = rd_field;
            end
            default: begin
                bundle_d.illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = !valid_q || out_ready;

    // Flush only kills the valid bit; the data fields may keep stale contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                bundle_q <= bundle_d;
            end
        end
    end

    assign out_valid   = valid_q;
    assign ALU_Control = bundle_q.ctrl;
    assign operand_A   = bundle_q.op_a;
    assign operand_B   = bundle_q.op_b;
    assign branch_op   = bundle_q.branch;
    assign out_rd      = bundle_q.rd;
    assign out_pc      = bundle_q.pc;
    assign out_imm     = bundle_q.imm;
    assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions with
// hand-computed bundles, checked by an independent monitor process.
module tb_alu_issue_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic        branch_op;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic        illegal;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    int    checks;
    int    failures;
    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur_exp;
    string cur_name;
    logic  acc_flag;

    alu_issue_stage #(.XLEN(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_Control (ALU_Control),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .branch_op   (branch_op),
        .out_rd      (out_rd),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [140:0] got, input logic [140:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic br, input logic [4:0] rd, input logic [31:0] pc,
                                input logic [31:0] imm, input logic ill);
        return {c, a, b, br, rd, pc, imm, ill};
    endfunction

    function automatic exp_t dut_bundle();
        return {ALU_Control, operand_A, operand_B, branch_op, out_rd, out_pc, out_imm, illegal};
    endfunction

    // Monitor: samples on the falling edge, updates the expected queue on the rising edge.
    initial begin
        logic ev;
        logic pend_pop;
        logic pend_push;
        exp_t pend_exp;
        string pend_name;
        pend_pop  = 1'b0;
        pend_push = 1'b0;
        pend_exp  = '0;
        pend_name = "";
        acc_flag  = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                exp_q.delete();
                name_q.delete();
                check("reset_valid", 141'(out_valid), 141'(0));
                check("reset_bundle", dut_bundle(), '0);
                pend_pop  = 1'b0;
                pend_push = 1'b0;
            end else begin
                ev = (exp_q.size() != 0);
                check("out_valid", 141'(out_valid), 141'(ev));
                check("in_ready", 141'(in_ready), 141'(!ev || out_ready));
                if (ev && out_valid) begin
                    check(name_q[0], dut_bundle(), exp_q[0]);
                end
                pend_pop  = ev && (flush || out_ready);
                pend_push = in_valid && (!ev || out_ready) && !flush;
                pend_exp  = cur_exp;
                pend_name = cur_name;
            end
            @(posedge clock);
            acc_flag = 1'b0;
            if (!reset) begin
                exp_q.delete();
                name_q.delete();
            end else begin
                if (pend_pop && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(name_q.pop_front());
                end
                if (pend_push) begin
                    exp_q.push_back(pend_exp);
                    name_q.push_back(pend_name);
                    acc_flag = 1'b1;
                end
            end
        end
    end

    task automatic drive(input string nm, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        cur_exp     = e;
        cur_name    = nm;
    endtask

    task automatic wait_accept(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!acc_flag && n < 20);
        if (!acc_flag) begin
            checks++;
            failures++;
            $display("FAIL %s_accept got=timeout want=accepted", nm);
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input string nm, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic br, input logic [4:0] rd, input logic [31:0] imm,
                        input logic ill);
        drive(nm, instr, pc, rs1, rs2, mk(c, a, b, br, rd, pc, imm, ill));
        wait_accept(nm);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_pc       = '0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        cur_exp     = '0;
        cur_name    = "none";
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        idle(1);

        // Back-to-back stream, one instruction per cycle.
        send("addi",  32'hFFD10093, 32'h0000_0100, 32'd10,        32'd0,
             6'b000000, 32'd10, 32'hFFFF_FFFD, 1'b0, 5'd1, 32'hFFFF_FFFD, 1'b0);
        send("srai",  32'h40335293, 32'h0000_0104, 32'h8000_0000, 32'h55,
             6'b001101, 32'h8000_0000, 32'd3, 1'b0, 5'd5, 32'h0000_0403, 1'b0);
        send("sub",   32'h402081B3, 32'h0000_0108, 32'd100,       32'd30,
             6'b001000, 32'd100, 32'd30, 1'b0, 5'd3, 32'd0, 1'b0);
        send("bltu",  32'h00526463, 32'h0000_010C, 32'd4,         32'hFFFF_FFFB,
             6'b010110, 32'd4, 32'hFFFF_FFFB, 1'b1, 5'd0, 32'd8, 1'b0);
        send("beq_neg", 32'hFE000EE3, 32'h0000_0110, 32'd7,       32'd7,
             6'b010000, 32'd7, 32'd7, 1'b1, 5'd0, 32'hFFFF_FFFC, 1'b0);
        send("jal_wrap", 32'h010000EF, 32'hFFFF_FFFC, 32'h1111,   32'h2222,
             6'b011111, 32'd0, 32'd0, 1'b0, 5'd1, 32'd16, 1'b0);
        send("jalr",  32'h004100E7, 32'h0000_0200, 32'h1234,      32'h5678,
             6'b111111, 32'h0000_0204, 32'd0, 1'b0, 5'd1, 32'd4, 1'b0);
        idle(2);

        send("lui",   32'h123453B7, 32'h0000_0300, 32'hAAAA,      32'hBBBB,
             6'b000000, 32'd0, 32'h1234_5000, 1'b0, 5'd7, 32'h1234_5000, 1'b0);
        send("auipc", 32'hFFFFF417, 32'h0000_1000, 32'hAAAA,      32'hBBBB,
             6'b000000, 32'h0000_1000, 32'hFFFF_F000, 1'b0, 5'd8, 32'hFFFF_F000, 1'b0);
        send("sw",    32'hFE532C23, 32'h0000_0304, 32'h2000,      32'hDEAD,
             6'b000000, 32'h2000, 32'hFFFF_FFF8, 1'b0, 5'd0, 32'hFFFF_FFF8, 1'b0);
        send("lw",    32'h00C52483, 32'h0000_0308, 32'h4000,      32'h0,
             6'b000000, 32'h4000, 32'd12, 1'b0, 5'd9, 32'd12, 1'b0);
        send("sltu",  32'h003130B3, 32'h0000_030C, 32'd1,         32'd2,
             6'b000011, 32'd1, 32'd2, 1'b0, 5'd1, 32'd0, 1'b0);
        send("slli",  32'h01F09093, 32'h0000_0310, 32'hF,         32'h0,
             6'b000001, 32'hF, 32'd31, 1'b0, 5'd1, 32'd31, 1'b0);
        send("andi",  32'hFFF0F093, 32'h0000_0314, 32'hAA,        32'h0,
             6'b000111, 32'hAA, 32'hFFFF_FFFF, 1'b0, 5'd1, 32'hFFFF_FFFF, 1'b0);
        send("ill_opc", 32'hFFFFFFFF, 32'h0000_0318, 32'd5,       32'd6,
             6'b000000, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        send("ill_f7", 32'h020000B3, 32'h0000_031C, 32'd3,        32'd4,
             6'b000000, 32'd3, 32'd4, 1'b0, 5'd1, 32'd0, 1'b1);
        send("ill_sub_f3", 32'h400010B3, 32'h0000_0320, 32'd3,    32'd4,
             6'b001001, 32'd3, 32'd4, 1'b0, 5'd1, 32'd0, 1'b1);
        send("ill_br", 32'h00002063, 32'h0000_0324, 32'd1,        32'd2,
             6'b010010, 32'd1, 32'd2, 1'b1, 5'd0, 32'd0, 1'b1);
        idle(2);

        // Stall for three cycles with the next instruction waiting.
        out_ready = 1'b0;
        send("stall_a", 32'h402081B3, 32'h0000_0400, 32'd9,       32'd4,
             6'b001000, 32'd9, 32'd4, 1'b0, 5'd3, 32'd0, 1'b0);
        drive("stall_b", 32'hFFD10093, 32'h0000_0404, 32'd20, 32'd0,
              mk(6'b000000, 32'd20, 32'hFFFF_FFFD, 1'b0, 5'd1, 32'h0000_0404, 32'hFFFF_FFFD, 1'b0));
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        wait_accept("stall_b");
        idle(2);

        // Flush kills both the held and the incoming instruction.
        out_ready = 1'b0;
        send("flush_hold", 32'h123453B7, 32'h0000_0500, 32'd0,    32'd0,
             6'b000000, 32'd0, 32'h1234_5000, 1'b0, 5'd7, 32'h1234_5000, 1'b0);
        drive("flush_in", 32'h00C52483, 32'h0000_0504, 32'h10, 32'h0,
              mk(6'b000000, 32'h10, 32'd12, 1'b0, 5'd9, 32'h0000_0504, 32'd12, 1'b0));
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(2);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        send("rst_hold", 32'h402081B3, 32'h0000_0600, 32'd50,     32'd8,
             6'b001000, 32'd50, 32'd8, 1'b0, 5'd3, 32'd0, 1'b0);
        drive("rst_in", 32'hFFD10093, 32'h0000_0604, 32'd1, 32'd0,
              mk(6'b000000, 32'd1, 32'hFFFF_FFFD, 1'b0, 5'd1, 32'h0000_0604, 32'hFFFF_FFFD, 1'b0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_async_valid", 141'(out_valid), 141'(0));
        check("rst_async_bundle", dut_bundle(), '0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(1);

        send("post_rst", 32'h004100E7, 32'h0000_0700, 32'h0,      32'h0,
             6'b111111, 32'h0000_0704, 32'd0, 1'b0, 5'd1, 32'd4, 1'b0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
